// File: rtl/egress_receiver.sv
// egress_receiver: accepts beats from the granted ingress port, tracks transfers and queues them in a FIFO
module egress_receiver #(
    parameter int DW        = 32,
    parameter int DEPTH     = 4,
    parameter int MAX_BEATS = 16
) (
    input  logic          clk,
    input  logic          rstN,
    input  logic          int_valid,
    input  logic [DW-1:0] int_data,
    input  logic          int_last,
    input  logic [1:0]    int_sel,
    output logic          int_ready,
    output logic          trans_started,
    output logic          eg_valid,
    output logic [DW-1:0] eg_data,
    output logic [1:0]    eg_port,
    output logic          eg_last,
    input  logic          eg_ready,
    output logic          err_port,
    output logic          err_len
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(MAX_BEATS + 1);

    typedef enum logic {IDLE, XFER} state_t;

    state_t          state, state_nxt;
    logic [DW-1:0]   mem_data [DEPTH];
    logic [1:0]      mem_port [DEPTH];
    logic            mem_last [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic [BW-1:0]   beat_cnt, beat_nxt;
    logic [1:0]      cur_port, cur_nxt, st_port;
    logic            st_last, set_ep, set_el;
    logic            accept, pop;

    assign int_ready     = rstN && (count < CW'(DEPTH));
    assign accept        = int_valid && int_ready;
    assign eg_valid      = count != '0;
    assign pop           = eg_valid && eg_ready;
    assign eg_data       = mem_data[rd_ptr];
    assign eg_port       = mem_port[rd_ptr];
    assign eg_last       = mem_last[rd_ptr];
    assign trans_started = state == XFER;

    // Transfer tracking: decides the stored tag/last bit and the next transfer state
    always_comb begin
        state_nxt = state;
        beat_nxt  = beat_cnt;
        cur_nxt   = cur_port;
        st_port   = int_sel;
        st_last   = int_last;
        set_ep    = 1'b0;
        set_el    = 1'b0;
        if (accept) begin
            if (state == IDLE) begin
                if (!int_last) begin
                    state_nxt = XFER;
                    cur_nxt   = int_sel;
                    beat_nxt  = BW'(1);
                end
            end else begin
                beat_nxt = beat_cnt + 1'b1;
                st_port  = cur_port;
                set_ep   = int_sel != cur_port;
                if (int_last) begin
                    state_nxt = IDLE;
                end else if (beat_nxt == BW'(MAX_BEATS)) begin
                    st_last   = 1'b1;
                    set_el    = 1'b1;
                    state_nxt = IDLE;
                end
            end
        end
    end

    // Transfer state, beat counter, latched port and sticky error flags
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state    <= IDLE;
            beat_cnt <= '0;
            cur_port <= '0;
            err_port <= 1'b0;
            err_len  <= 1'b0;
        end else begin
            state    <= state_nxt;
            beat_cnt <= beat_nxt;
            cur_port <= cur_nxt;
            err_port <= err_port | set_ep;
            err_len  <= err_len | set_el;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(accept) - CW'(pop);
        end
    end

    // FIFO storage needs no reset; contents are ignored while empty
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_data[wr_ptr] <= int_data;
            mem_port[wr_ptr] <= st_port;
            mem_last[wr_ptr] <= st_last;
        end
    end
endmodule

// File: tb/tb_egress_receiver.sv
// tb_egress_receiver: directed scenarios plus random traffic checked against a queue-based reference model
module tb_egress_receiver;
    localparam int DW = 32;
    localparam int DEPTH = 4;
    localparam int MAX_BEATS = 16;

    logic          clk = 1'b0;
    logic          rstN = 1'b0;
    logic          int_valid = 1'b0;
    logic [DW-1:0] int_data = '0;
    logic          int_last = 1'b0;
    logic [1:0]    int_sel = '0;
    logic          int_ready, trans_started, eg_valid, eg_last, err_port, err_len;
    logic [DW-1:0] eg_data;
    logic [1:0]    eg_port;
    logic          eg_ready = 1'b0;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [DW-1:0] d;
        logic [1:0]    p;
        logic          l;
    } beat_t;

    beat_t      ref_q[$];
    bit         ref_xfer;
    logic [1:0] ref_cur;
    int         ref_n;
    bit         ref_ep, ref_el;

    egress_receiver #(.DW(DW), .DEPTH(DEPTH), .MAX_BEATS(MAX_BEATS)) dut (
        .clk(clk), .rstN(rstN), .int_valid(int_valid), .int_data(int_data),
        .int_last(int_last), .int_sel(int_sel), .int_ready(int_ready),
        .trans_started(trans_started), .eg_valid(eg_valid), .eg_data(eg_data),
        .eg_port(eg_port), .eg_last(eg_last), .eg_ready(eg_ready),
        .err_port(err_port), .err_len(err_len)
    );

    always #5 clk = ~clk;

    task automatic ref_clear();
        ref_q.delete();
        ref_xfer = 0;
        ref_cur = '0;
        ref_n = 0;
        ref_ep = 0;
        ref_el = 0;
    endtask

    // Transfer rules applied to one clock edge, using the pre-edge occupancy
    task automatic ref_edge(input logic v, input logic [DW-1:0] d, input logic l, input logic [1:0] s, input logic r);
        bit acc, pp;
        beat_t b;
        acc = v && ref_q.size() < DEPTH;
        pp = ref_q.size() != 0 && r;
        if (pp) void'(ref_q.pop_front());
        if (acc) begin
            b.d = d;
            if (!ref_xfer) begin
                b.p = s;
                b.l = l;
                if (!l) begin
                    ref_xfer = 1;
                    ref_cur = s;
                    ref_n = 1;
                end
            end else begin
                ref_n++;
                b.p = ref_cur;
                if (s != ref_cur) ref_ep = 1;
                b.l = 1'b1;
                if (l) ref_xfer = 0;
                else if (ref_n == MAX_BEATS) begin
                    ref_el = 1;
                    ref_xfer = 0;
                end else b.l = 1'b0;
            end
            ref_q.push_back(b);
        end
    endtask

    task automatic step(input logic v, input logic [DW-1:0] d, input logic l, input logic [1:0] s, input logic r);
        int_valid = v;
        int_data = d;
        int_last = l;
        int_sel = s;
        eg_ready = r;
        @(posedge clk);
        ref_edge(v, d, l, s, r);
        #1;
    endtask

    task automatic enter_reset();
        int_valid = 0;
        int_last = 0;
        eg_ready = 0;
        rstN = 0;
        ref_clear();
        #2;
    endtask

    task automatic leave_reset();
        @(posedge clk);
        #1;
        rstN = 1;
        #1;
    endtask

    task automatic test_reset();
        enter_reset();
        checks++; if (int_ready !== 1'b0) begin errors++; $display("FAIL reset_int_ready got %b exp 0", int_ready); end
        checks++; if (eg_valid !== 1'b0) begin errors++; $display("FAIL reset_eg_valid got %b exp 0", eg_valid); end
        checks++; if (trans_started !== 1'b0) begin errors++; $display("FAIL reset_trans got %b exp 0", trans_started); end
        checks++; if ({err_port, err_len} !== 2'b00) begin errors++; $display("FAIL reset_errs got %b exp 00", {err_port, err_len}); end
        leave_reset();
        checks++; if (int_ready !== 1'b1) begin errors++; $display("FAIL release_int_ready got %b exp 1", int_ready); end
    endtask

    task automatic test_single_beat();
        enter_reset();
        leave_reset();
        step(1, 32'hA5, 1, 2'd2, 1);
        checks++; if (eg_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", eg_valid); end
        checks++; if (eg_data !== 32'hA5) begin errors++; $display("FAIL single_data got %0h exp a5", eg_data); end
        checks++; if (eg_port !== 2'd2) begin errors++; $display("FAIL single_port got %0d exp 2", eg_port); end
        checks++; if (eg_last !== 1'b1) begin errors++; $display("FAIL single_last got %b exp 1", eg_last); end
        checks++; if (trans_started !== 1'b0) begin errors++; $display("FAIL single_trans got %b exp 0", trans_started); end
        step(0, 0, 0, 2'd0, 1);
        checks++; if (eg_valid !== 1'b0) begin errors++; $display("FAIL single_drain got %b exp 0", eg_valid); end
    endtask

    task automatic test_three_beats();
        enter_reset();
        leave_reset();
        for (int i = 1; i <= 3; i++) begin
            step(1, 32'h100 + i, i == 3, 2'd1, 1);
            checks++; if (trans_started !== (i != 3)) begin errors++; $display("FAIL three_trans beat %0d got %b exp %b", i, trans_started, i != 3); end
            checks++; if (eg_data !== 32'h100 + i) begin errors++; $display("FAIL three_data beat %0d got %0h exp %0h", i, eg_data, 32'h100 + i); end
            checks++; if (eg_last !== (i == 3) || eg_port !== 2'd1) begin errors++; $display("FAIL three_tag beat %0d got last=%b port=%0d exp last=%b port=1", i, eg_last, eg_port, i == 3); end
        end
    endtask

    task automatic test_backpressure();
        enter_reset();
        leave_reset();
        for (int i = 0; i < 5; i++) begin
            checks++; if (int_ready !== (i < DEPTH)) begin errors++; $display("FAIL bp_ready beat %0d got %b exp %b", i, int_ready, i < DEPTH); end
            step(1, i, 1, 2'd0, 0);
        end
        checks++; if (int_ready !== 1'b0) begin errors++; $display("FAIL bp_full got %b exp 0", int_ready); end
        step(1, 4, 1, 2'd0, 1);
        checks++; if (int_ready !== 1'b1) begin errors++; $display("FAIL bp_after_pop got %b exp 1", int_ready); end
        step(1, 4, 1, 2'd0, 0);
        for (int k = 1; k <= 4; k++) begin
            checks++; if (eg_valid !== 1'b1 || eg_data !== k) begin errors++; $display("FAIL bp_order got v=%b d=%0d exp v=1 d=%0d", eg_valid, eg_data, k); end
            step(0, 0, 0, 2'd0, 1);
        end
        checks++; if (eg_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %b exp 0", eg_valid); end
    endtask

    task automatic test_port_switch();
        enter_reset();
        leave_reset();
        step(1, 32'h10, 0, 2'd0, 1);
        checks++; if (err_port !== 1'b0) begin errors++; $display("FAIL sw_err_early got %b exp 0", err_port); end
        step(1, 32'h11, 0, 2'd3, 1);
        checks++; if (eg_data !== 32'h11 || eg_port !== 2'd0) begin errors++; $display("FAIL sw_tag got d=%0h p=%0d exp d=11 p=0", eg_data, eg_port); end
        checks++; if (err_port !== 1'b1) begin errors++; $display("FAIL sw_err got %b exp 1", err_port); end
        step(1, 32'h12, 1, 2'd0, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 2'd0, 1);
        checks++; if (err_port !== 1'b1 || trans_started !== 1'b0) begin errors++; $display("FAIL sw_sticky got err=%b trans=%b exp err=1 trans=0", err_port, trans_started); end
    endtask

    task automatic test_max_beats();
        enter_reset();
        leave_reset();
        for (int i = 1; i <= 17; i++) begin
            step(1, i, 0, 2'd1, 1);
            checks++; if (eg_data !== i || eg_last !== (i == MAX_BEATS)) begin errors++; $display("FAIL max_beat %0d got d=%0d last=%b exp d=%0d last=%b", i, eg_data, eg_last, i, i == MAX_BEATS); end
            checks++; if (trans_started !== (i != MAX_BEATS)) begin errors++; $display("FAIL max_trans beat %0d got %b exp %b", i, trans_started, i != MAX_BEATS); end
            checks++; if (err_len !== (i >= MAX_BEATS)) begin errors++; $display("FAIL max_err beat %0d got %b exp %b", i, err_len, i >= MAX_BEATS); end
        end
    endtask

    task automatic test_reset_mid_xfer();
        enter_reset();
        leave_reset();
        step(1, 32'h20, 0, 2'd2, 0);
        step(1, 32'h21, 0, 2'd2, 0);
        checks++; if (eg_valid !== 1'b1 || trans_started !== 1'b1) begin errors++; $display("FAIL mid_pre got v=%b t=%b exp 1 1", eg_valid, trans_started); end
        enter_reset();
        checks++; if ({eg_valid, trans_started, int_ready} !== 3'b000) begin errors++; $display("FAIL mid_in_reset got %b exp 000", {eg_valid, trans_started, int_ready}); end
        leave_reset();
        checks++; if (int_ready !== 1'b1 || eg_valid !== 1'b0) begin errors++; $display("FAIL mid_release got r=%b v=%b exp r=1 v=0", int_ready, eg_valid); end
        step(1, 32'h30, 1, 2'd3, 1);
        checks++; if (trans_started !== 1'b0 || eg_port !== 2'd3 || eg_last !== 1'b1) begin errors++; $display("FAIL mid_first got t=%b p=%0d l=%b exp t=0 p=3 l=1", trans_started, eg_port, eg_last); end
    endtask

    task automatic test_random();
        logic [1:0] s;
        enter_reset();
        leave_reset();
        s = 2'($urandom_range(0, 3));
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) s = 2'($urandom_range(0, 3));
            step($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 5) == 0, s, $urandom_range(0, 9) < 5);
            checks++; if (int_ready !== (ref_q.size() < DEPTH)) begin errors++; $display("FAIL rnd_ready cyc %0d got %b exp %b", i, int_ready, ref_q.size() < DEPTH); end
            checks++; if (eg_valid !== (ref_q.size() != 0)) begin errors++; $display("FAIL rnd_valid cyc %0d got %b exp %b", i, eg_valid, ref_q.size() != 0); end
            if (ref_q.size() != 0) begin
                checks++; if (eg_data !== ref_q[0].d || eg_port !== ref_q[0].p || eg_last !== ref_q[0].l) begin errors++; $display("FAIL rnd_head cyc %0d got %0h/%0d/%b exp %0h/%0d/%b", i, eg_data, eg_port, eg_last, ref_q[0].d, ref_q[0].p, ref_q[0].l); end
            end
            checks++; if (trans_started !== ref_xfer) begin errors++; $display("FAIL rnd_trans cyc %0d got %b exp %b", i, trans_started, ref_xfer); end
            checks++; if (err_port !== ref_ep || err_len !== ref_el) begin errors++; $display("FAIL rnd_errs cyc %0d got %b%b exp %b%b", i, err_port, err_len, ref_ep, ref_el); end
        end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_three_beats();
        test_backpressure();
        test_port_switch();
        test_max_beats();
        test_reset_mid_xfer();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
